uart_rx: RTL

- UART receiver: the receive-side counterpart of the team's UART transmitter (shift-register-based, LSB-first serial stream).
- Samples an asynchronous serial line, detects start bit, shifts in DATA_BITS LSB-first, checks one stop bit, presents a parallel byte with a one-cycle valid strobe.
- No parity; 8N1 framing by default; no backpressure (consumer must take data on the valid pulse or read the held data_out later).

---
 rtl/uart_rx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchronizer, start-bit validation at mid-bit,
// LSB-first data shift, stop-bit check with one-cycle valid / frame_err strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            data_out  <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = data_out;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (clk_cnt == CNT_MID) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    // New bit enters at the MSB so the first bit ends up in bit 0
                    shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                clk_cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
